// File: rtl/dmem_subword.sv
// Byte-addressable data memory with byte/half/word loads and stores and a one-deep response stage.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of ignoring low bits.
module dmem_subword #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_fault_q, resp_fault_d;

  logic [IdxW-1:0]   word_idx;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] hi_addr;
  logic              out_of_range;
  logic              misaligned;
  logic              fault;
  logic              accept;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;

  assign word_idx     = req_addr_i[IdxW+1:2];
  assign lane         = req_addr_i[1:0];
  // Any address bit above the word index selects a word beyond the array.
  assign hi_addr      = req_addr_i >> (IdxW + 2);
  assign out_of_range = |hi_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (req_size_i == 2'b01) misaligned = lane[0];
    else if (req_size_i == 2'b10) misaligned = |lane;
  end
`else
  assign misaligned = 1'b0;
`endif

  assign fault       = (req_size_i == 2'b11) || out_of_range || misaligned;
  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign wr_en       = accept && req_write_i && !fault;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata_i[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Array has no reset; contents survive reset_ni.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};
  assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0;
    unique case (req_size_i)
      2'b00: load_data = req_unsigned_i ? {24'h0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_data = req_unsigned_i ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      2'b10: load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_fault_d = fault;
      resp_rdata_d = (fault || req_write_i) ? 32'h0 : load_data;
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_fault_o = resp_fault_q;

endmodule

// File: tb/tb_dmem_subword.sv
// Directed bench for dmem_subword: sub-word stores/loads, faults, stall back-pressure and reset.
module tb_dmem_subword;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_subword #(.DEPTH(128), .ADDR_W(32)) dut (
    .clock_i       (clock),
    .reset_ni      (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_size_i    (req_size),
    .req_unsigned_i(req_unsigned),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_rdata_o  (resp_rdata),
    .resp_fault_o  (resp_fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // One request with resp_ready high; response is checked one edge after acceptance.
  task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_fault);
    drive(w, sz, uns, addr, wd);
    tick();
    req_valid = 1'b0;
    chk({tag, ".valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, ".rdata"}, resp_rdata, exp_rd);
    chk({tag, ".fault"}, {31'h0, resp_fault}, {31'h0, exp_fault});
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;
    #12;
    chk("rst.valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.fault", {31'h0, resp_fault}, 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rst.ready", {31'h0, req_ready}, 32'h1);

    xact("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA7F, 32'h0, 1'b0);
    xact("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
    xact("lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    xact("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    xact("lb11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0);
    xact("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xact("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    xact("lh11",  1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
    xact("sw12",  1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 32'h0, 1'b1);
    xact("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0);
`else
    xact("lh11",  1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h00007FEF, 1'b0);
    xact("lw13",  1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'hDEAD7FEF, 1'b0);
`endif

    xact("sw14",  1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, 32'h0, 1'b0);
    xact("sh16",  1'b1, 2'b01, 1'b0, 32'h16, 32'hAAAA8001, 32'h0, 1'b0);
    xact("lw14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h80013344, 1'b0);
    xact("sw18",  1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("sw00",  1'b1, 2'b10, 1'b0, 32'h00, 32'h01020304, 32'h0, 1'b0);

    xact("lw200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    xact("sw200", 1'b1, 2'b10, 1'b0, 32'h200, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("lw00",  1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h01020304, 1'b0);
    xact("rsvsw", 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("lw00b", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'h01020304, 1'b0);

    // Back-to-back loads, second response stalled for three cycles.
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    chk("b2b.A", resp_rdata, 32'hDEAD7FEF);
    drive(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    tick();
    chk("b2b.B", resp_rdata, 32'h80013344);
    resp_ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    #1;
    chk("b2b.ready_lo", {31'h0, req_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b.hold_v", {31'h0, resp_valid}, 32'h1);
      chk("b2b.hold_d", resp_rdata, 32'h80013344);
      chk("b2b.hold_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    #1;
    chk("b2b.ready_hi", {31'h0, req_ready}, 32'h1);
    tick();
    chk("b2b.C", resp_rdata, 32'h01020304);
    drive(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("b2b.D", resp_rdata, 32'hCAFEF00D);
    chk("b2b.Dv", {31'h0, resp_valid}, 32'h1);
    tick();
    chk("b2b.idle", {31'h0, resp_valid}, 32'h0);

    // Reset with a stalled response pending.
    resp_ready = 1'b0;
    drive(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("mrst.pend", {31'h0, resp_valid}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst.valid", {31'h0, resp_valid}, 32'h0);
    chk("mrst.rdata", resp_rdata, 32'h0);
    #2;
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    tick();
    xact("mrst.lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h80013344, 1'b0);
    xact("mrst.lw18", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_subword.md
DMEM_SUBWORD -- requirements
Module: dmem_subword

Interface
REQ-001 Parameter DEPTH, default 128: number of 32-bit words; power of two, minimum 4.
REQ-002 Parameter ADDR_W, default 32: byte-address width; SHALL be at least log2(DEPTH)+2.
REQ-003 clock  input  1: single clock, all state updates on rising edge.
REQ-004 reset_n  input  1: reset, asynchronous and active-low.
REQ-005 req_valid  input  1: request present.
REQ-006 req_ready  output  1: request accepted on the edge where req_valid && req_ready.
REQ-007 req_write  input  1: 1 = store, 0 = load.
REQ-008 req_size  input  2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_unsigned  input  1: load zero-extends when 1 and sign-extends when 0; ignored on stores.
REQ-010 req_addr  input  ADDR_W: byte address.
REQ-011 req_wdata  input  32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1: response present.
REQ-013 resp_ready  input  1: response consumed on the edge where resp_valid && resp_ready.
REQ-014 resp_rdata  output  32: extended load data; 0 for stores and faults.
REQ-015 resp_fault  output  1: request was rejected (misaligned, out of range or reserved size).

Function
REQ-016 Word index SHALL be req_addr[log2(DEPTH)+1:2]; byte lane SHALL be req_addr[1:0], little-endian (lane 0 = bits [7:0]).
REQ-017 req_ready SHALL equal !resp_valid || resp_ready, so back-to-back requests sustain one per cycle.
REQ-018 Every accepted request SHALL produce exactly one response, with resp_valid asserted on the edge after acceptance.
REQ-019 resp_valid, resp_rdata and resp_fault SHALL hold stable while resp_valid && !resp_ready.
REQ-020 On a response handshake with no new acceptance in the same cycle, resp_valid SHALL deassert on that edge.
REQ-021 Store byte SHALL write only lane addr[1:0]; store half SHALL write lanes {addr[1],0} and {addr[1],1}; store word SHALL write all 4 lanes; untouched lanes SHALL keep their value.
REQ-022 Memory write SHALL occur on the acceptance edge, so a load accepted on the next cycle to the same word returns the new data.
REQ-023 A load SHALL select the addressed byte or half and extend it to 32 bits per req_unsigned; a word load SHALL return the word unchanged.
REQ-024 req_size = 11 SHALL be a fault, with no memory write and resp_rdata = 0.
REQ-025 A request is out of range when any req_addr bit above log2(DEPTH)+1 is set; this SHALL be a fault with no write and resp_rdata = 0.
REQ-026 Accepted requests with req_valid low in the same cycle SHALL NOT exist; req_* inputs are ignored when req_valid is 0.

Reset
REQ-027 While reset_n = 0: resp_valid = 0, resp_rdata = 0, resp_fault = 0; req_ready = 1 after reset deassertion.
REQ-028 Reset asserted mid-transaction SHALL discard any pending response; a store already accepted SHALL keep its memory effect.
REQ-029 Memory array contents SHALL NOT be reset; a load before any store to that word returns an undefined value.

Configuration
REQ-030 With macro DMEM_ALIGN_CHECK_EN defined, a misaligned half (addr[0] = 1) or misaligned word (addr[1:0] != 00) SHALL fault, with no write and resp_rdata = 0.
REQ-031 Without DMEM_ALIGN_CHECK_EN, misalignment SHALL NOT fault: halfword accesses ignore addr[0], word accesses ignore addr[1:0], and resp_fault reports only reserved-size and out-of-range faults.

Verification
REQ-032 Store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_rdata 0xDEADBEEF, fault 0, one cycle after each acceptance.
REQ-033 Store byte 0x7F at 0x11, then load word 0x10 -> 0xDEAD7FEF; load byte signed at 0x13 -> 0xFFFFFFDE; load byte unsigned at 0x13 -> 0x000000DE.
REQ-034 Load half at 0x11 -> with DMEM_ALIGN_CHECK_EN: fault 1, rdata 0, memory unchanged; without it: signed half of 0x10 = 0x00007FEF.
REQ-035 Load at 0x200 with DEPTH = 128 -> fault 1, rdata 0; a store to 0x200 leaves word 0 unchanged.
REQ-036 Four back-to-back loads with resp_ready low for 3 cycles on the second response -> req_ready low during the stall, response held stable, all four responses delivered in order, none dropped or duplicated.
REQ-037 Assert reset_n low while resp_valid = 1 and resp_ready = 0 -> resp_valid drops immediately; after release, a load of the previously stored address returns the stored data.
